// File: rtl/ctrl_pipe.sv
// ctrl_pipe -- registered RV32I instruction-decode / control stage.
//
// Decodes a 32-bit instruction into the datapath control bundle and holds it
// in the ID/EX register. A valid/ready handshake connects it to fetch (in_*)
// and execute (ex_*). Issue stalls on a load-use hazard and, when the M
// extension is built in, for DIV_LAT-1 cycles after a divide/remainder.
// A flush from EX kills both the ID/EX slot and the instruction on offer.
//
// Ports:
//   clk, rst         clock (rising edge), synchronous active-high reset
//   in_valid/in_instr/in_ready   fetch handshake (in_ready is combinational)
//   flush            EX redirect, overrides hold, hazard and divide wait
//   ex_ready         EX consumes the ID/EX register this cycle
//   ex_valid         ID/EX holds a real instruction
//   RegWe, ASel, BSel, DRAMWE, RWSel, SextOpe, DRAM_EX_TYPE, PCCTRL
//                    registered control bundle
//   ex_rd, ex_is_load, ex_mdu_op, ex_mdu, ex_illegal
//                    registered side-band decode information
module ctrl_pipe #(
    parameter bit ENABLE_M = 1'b0,
    parameter int DIV_LAT  = 8
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        in_valid,
    input  logic [31:0] in_instr,
    output logic        in_ready,
    input  logic        flush,
    input  logic        ex_ready,
    output logic        ex_valid,
    output logic        RegWe,
    output logic        ASel,
    output logic        BSel,
    output logic        DRAMWE,
    output logic [1:0]  RWSel,
    output logic [4:0]  SextOpe,
    output logic [1:0]  DRAM_EX_TYPE,
    output logic [3:0]  PCCTRL,
    output logic [4:0]  ex_rd,
    output logic        ex_is_load,
    output logic [2:0]  ex_mdu_op,
    output logic        ex_mdu,
    output logic        ex_illegal
);

    localparam logic [4:0] CNT_INIT = 5'(DIV_LAT - 1);

    typedef struct packed {
        logic       reg_we;
        logic       a_sel;
        logic       b_sel;
        logic       dram_we;
        logic [1:0] rw_sel;
        logic [4:0] sext;      // {i,s,b,j,u}
        logic [1:0] dram_type;
        logic [3:0] pcctrl;    // {BRANCH, BJ, cond}
        logic [4:0] rd;
        logic       is_load;
        logic [2:0] mdu_op;
        logic       mdu;
        logic       illegal;
    } ctrl_t;

    typedef enum logic {S_RUN, S_DIV_WAIT} state_t;

    // ---------------------------------------------------------------- decode
    logic [4:0] w_op;
    logic [2:0] w_f3;
    logic [4:0] w_rd;
    logic       w_full, w_is_r, w_is_lui, w_is_auipc, w_is_jal, w_is_s, w_is_b;
    logic       w_is_load, w_is_opimm, w_is_jalr, w_is_i, w_is_u, w_is_m;
    logic       w_known, w_is_slt;
    logic [1:0] w_cond;
    logic [1:0] w_use_rs;
    logic [4:0] w_rs [2];
    ctrl_t      w_dec;

    assign w_op       = in_instr[6:2];
    assign w_f3       = in_instr[14:12];
    assign w_rd       = in_instr[11:7];
    assign w_rs[0]    = in_instr[19:15];
    assign w_rs[1]    = in_instr[24:20];
    assign w_full     = (in_instr[1:0] == 2'b11);   // compressed space decodes as NOP
    assign w_is_r     = (w_op == 5'b01100);
    assign w_is_lui   = (w_op == 5'b01101);
    assign w_is_auipc = (w_op == 5'b00101);
    assign w_is_jal   = (w_op == 5'b11011);
    assign w_is_s     = (w_op == 5'b01000);
    assign w_is_b     = (w_op == 5'b11000);
    assign w_is_load  = (w_op == 5'b00000);
    assign w_is_opimm = (w_op == 5'b00100);
    assign w_is_jalr  = (w_op == 5'b11001);
    assign w_is_i     = w_is_load | w_is_opimm | w_is_jalr;
    assign w_is_u     = w_is_lui | w_is_auipc;
    assign w_is_m     = w_is_r & (in_instr[31:25] == 7'b0000001);
    // M encodings without the M unit are reported as illegal.
    assign w_known    = (w_is_r | w_is_u | w_is_jal | w_is_s | w_is_b | w_is_i)
                        & ~(w_is_m & ~ENABLE_M);
    // SLT/SLTU/SLTI/SLTIU; func3 010/011 of an M op is MULHSU/MULHU instead.
    assign w_is_slt   = ((w_is_r & ~w_is_m) | w_is_opimm) & (w_f3[2:1] == 2'b01);

    assign w_use_rs[0] = w_full & w_known & (w_is_r | w_is_i | w_is_s | w_is_b);
    assign w_use_rs[1] = w_full & w_known & (w_is_r | w_is_s | w_is_b);

    always_comb begin
        w_cond = 2'b11;
        case (w_f3)
            3'b000:         w_cond = 2'b00;
            3'b001:         w_cond = 2'b01;
            3'b100, 3'b110: w_cond = 2'b10;
            default:        w_cond = 2'b11;
        endcase
    end

    always_comb begin
        w_dec = '0;
        if (w_full) begin
            if (!w_known) begin
                w_dec.illegal = 1'b1;
            end else begin
                w_dec.reg_we    = ~(w_is_s | w_is_b) & (w_rd != 5'd0);
                w_dec.a_sel     = w_is_jal | w_is_b | w_is_auipc | w_is_slt;
                w_dec.b_sel     = ~((w_is_r & ~w_is_slt) | (w_is_opimm & w_is_slt));
                w_dec.dram_we   = w_is_s;
                if (w_is_load)
                    w_dec.rw_sel = 2'b01;
                else if (w_is_slt)
                    w_dec.rw_sel = 2'b11;
                else if (w_is_jal | w_is_jalr)
                    w_dec.rw_sel = 2'b10;
                else
                    w_dec.rw_sel = 2'b00;
                w_dec.sext      = {w_is_i, w_is_s, w_is_b, w_is_jal, w_is_u};
                w_dec.dram_type = w_f3[1:0];
                w_dec.pcctrl    = {w_is_b | w_is_jal | w_is_jalr, w_is_b, w_cond};
                w_dec.rd        = w_rd;
                w_dec.is_load   = w_is_load;
                w_dec.mdu       = w_is_m;
                w_dec.mdu_op    = w_is_m ? w_f3 : 3'b000;
            end
        end
    end

    // -------------------------------------------------------------- control
    state_t     r_state, w_state_next;
    logic [4:0] r_cnt, w_cnt_next;
    logic       r_valid;
    ctrl_t      r_ctrl;
    logic [1:0] w_rs_hit;
    logic       w_hazard, w_adv, w_accept;

    // Compare each source field against the load destination in EX.
    genvar gi;
    generate
        for (gi = 0; gi < 2; gi++) begin : g_rs_hit
            assign w_rs_hit[gi] = w_use_rs[gi] & (w_rs[gi] == r_ctrl.rd);
        end
    endgenerate

    assign w_hazard = r_valid & r_ctrl.is_load & (r_ctrl.rd != 5'd0) & in_valid
                      & (|w_rs_hit);
    assign w_adv    = ~r_valid | ex_ready;
    // During a flush the offered word is taken and thrown away.
    assign in_ready = ~rst & (flush | (w_adv & ~w_hazard & (r_state == S_RUN)));
    assign w_accept = in_valid & in_ready & ~flush;

    always_comb begin
        w_state_next = r_state;
        w_cnt_next   = r_cnt;
        if (flush) begin
            w_state_next = S_RUN;
            w_cnt_next   = 5'd0;
        end else begin
            case (r_state)
                S_RUN: begin
                    if (w_accept & w_dec.mdu & w_dec.mdu_op[2]) begin
                        w_state_next = S_DIV_WAIT;
                        w_cnt_next   = CNT_INIT;
                    end
                end
                S_DIV_WAIT: begin
                    w_cnt_next = r_cnt - 5'd1;
                    if (r_cnt <= 5'd1) begin
                        w_state_next = S_RUN;
                        w_cnt_next   = 5'd0;
                    end
                end
                default: begin
                    w_state_next = S_RUN;
                    w_cnt_next   = 5'd0;
                end
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state <= S_RUN;
            r_cnt   <= 5'd0;
            r_valid <= 1'b0;
            r_ctrl  <= '0;
        end else begin
            r_state <= w_state_next;
            r_cnt   <= w_cnt_next;
            if (flush) begin
                r_valid <= 1'b0;
            end else if (w_accept) begin
                r_valid <= 1'b1;
                r_ctrl  <= w_dec;
            end else if (w_adv) begin
                r_valid <= 1'b0;    // bubble: nothing issued, EX drained
            end
        end
    end

    assign ex_valid     = r_valid;
    assign RegWe        = r_ctrl.reg_we;
    assign ASel         = r_ctrl.a_sel;
    assign BSel         = r_ctrl.b_sel;
    assign DRAMWE       = r_ctrl.dram_we;
    assign RWSel        = r_ctrl.rw_sel;
    assign SextOpe      = r_ctrl.sext;
    assign DRAM_EX_TYPE = r_ctrl.dram_type;
    assign PCCTRL       = r_ctrl.pcctrl;
    assign ex_rd        = r_ctrl.rd;
    assign ex_is_load   = r_ctrl.is_load;
    assign ex_mdu_op    = r_ctrl.mdu_op;
    assign ex_mdu       = r_ctrl.mdu;
    assign ex_illegal   = r_ctrl.illegal;

endmodule

// File: tb/tb_ctrl_pipe.sv
// tb_ctrl_pipe -- directed bench for ctrl_pipe.
// dut_m: ENABLE_M=1, DIV_LAT=8. dut_n: ENABLE_M=0. Both share the stimulus.
// Control bundle compared as a 23-bit vector:
//   [22] RegWe [21] ASel [20] BSel [19] DRAMWE [18:17] RWSel [16:12] SextOpe
//   [11:10] DRAM_EX_TYPE [9:6] PCCTRL [5] ex_is_load [4:2] ex_mdu_op
//   [1] ex_mdu [0] ex_illegal
module tb_ctrl_pipe;

    logic        clk, rst, in_valid, flush, ex_ready;
    logic [31:0] in_instr;

    logic        m_in_ready, m_ex_valid, m_RegWe, m_ASel, m_BSel, m_DRAMWE;
    logic [1:0]  m_RWSel, m_DRAM_EX_TYPE;
    logic [4:0]  m_SextOpe, m_ex_rd;
    logic [3:0]  m_PCCTRL;
    logic        m_ex_is_load, m_ex_mdu, m_ex_illegal;
    logic [2:0]  m_ex_mdu_op;

    logic        n_in_ready, n_ex_valid, n_RegWe, n_ASel, n_BSel, n_DRAMWE;
    logic [1:0]  n_RWSel, n_DRAM_EX_TYPE;
    logic [4:0]  n_SextOpe, n_ex_rd;
    logic [3:0]  n_PCCTRL;
    logic        n_ex_is_load, n_ex_mdu, n_ex_illegal;
    logic [2:0]  n_ex_mdu_op;

    logic [22:0] m_ctrl, n_ctrl;
    assign m_ctrl = {m_RegWe, m_ASel, m_BSel, m_DRAMWE, m_RWSel, m_SextOpe, m_DRAM_EX_TYPE,
                     m_PCCTRL, m_ex_is_load, m_ex_mdu_op, m_ex_mdu, m_ex_illegal};
    assign n_ctrl = {n_RegWe, n_ASel, n_BSel, n_DRAMWE, n_RWSel, n_SextOpe, n_DRAM_EX_TYPE,
                     n_PCCTRL, n_ex_is_load, n_ex_mdu_op, n_ex_mdu, n_ex_illegal};

    localparam logic [22:0] MASK_ALL = 23'h7FFFFF;
    localparam logic [22:0] MASK_ALU = 23'h7FF33F;  // ignore DRAM type and cond
    localparam logic [22:0] MASK_MEM = 23'h7FFF3F;  // ignore cond
    localparam logic [22:0] MASK_BR  = 23'h7FF3FF;  // ignore DRAM type
    localparam logic [22:0] MASK_ILL = 23'h49F001;  // RegWe, DRAMWE, SextOpe, illegal

    localparam logic [31:0] I_ADD3  = 32'h002081B3;
    localparam logic [31:0] I_LW5   = 32'h0000A283;
    localparam logic [31:0] I_ADD6  = 32'h00128333;
    localparam logic [31:0] I_DIV7  = 32'h0220C3B3;
    localparam logic [31:0] I_BGE   = 32'h0020D463;
    localparam logic [31:0] I_SW    = 32'h0020A223;
    localparam logic [31:0] I_JAL   = 32'h010000EF;
    localparam logic [31:0] I_SLTI  = 32'h0050A213;
    localparam logic [31:0] I_AUIPC = 32'h00001417;
    localparam logic [31:0] I_NOP   = 32'h00000001;
    localparam logic [31:0] I_ILL   = 32'h0000007F;

    int n_vec = 0;
    int n_err = 0;

    ctrl_pipe #(.ENABLE_M(1'b1), .DIV_LAT(8)) dut_m (
        .clk(clk), .rst(rst), .in_valid(in_valid), .in_instr(in_instr),
        .in_ready(m_in_ready), .flush(flush), .ex_ready(ex_ready),
        .ex_valid(m_ex_valid), .RegWe(m_RegWe), .ASel(m_ASel), .BSel(m_BSel),
        .DRAMWE(m_DRAMWE), .RWSel(m_RWSel), .SextOpe(m_SextOpe),
        .DRAM_EX_TYPE(m_DRAM_EX_TYPE), .PCCTRL(m_PCCTRL), .ex_rd(m_ex_rd),
        .ex_is_load(m_ex_is_load), .ex_mdu_op(m_ex_mdu_op), .ex_mdu(m_ex_mdu),
        .ex_illegal(m_ex_illegal)
    );

    ctrl_pipe #(.ENABLE_M(1'b0), .DIV_LAT(8)) dut_n (
        .clk(clk), .rst(rst), .in_valid(in_valid), .in_instr(in_instr),
        .in_ready(n_in_ready), .flush(flush), .ex_ready(ex_ready),
        .ex_valid(n_ex_valid), .RegWe(n_RegWe), .ASel(n_ASel), .BSel(n_BSel),
        .DRAMWE(n_DRAMWE), .RWSel(n_RWSel), .SextOpe(n_SextOpe),
        .DRAM_EX_TYPE(n_DRAM_EX_TYPE), .PCCTRL(n_PCCTRL), .ex_rd(n_ex_rd),
        .ex_is_load(n_ex_is_load), .ex_mdu_op(n_ex_mdu_op), .ex_mdu(n_ex_mdu),
        .ex_illegal(n_ex_illegal)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL watchdog timeout");
        $fatal(1, "timeout");
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        rst = 1'b1; in_valid = 1'b0; flush = 1'b0; ex_ready = 1'b1; in_instr = 32'h0;
        tick();
        rst = 1'b0;
    endtask

    task automatic test_reset();
        rst = 1'b1; in_valid = 1'b1; flush = 1'b0; ex_ready = 1'b1; in_instr = I_ADD3;
        tick();
        tick();
        n_vec++;
        if (m_ex_valid !== 1'b0 || m_ctrl !== 23'h0 || m_ex_rd !== 5'd0) begin
            n_err++;
            $display("FAIL reset_state got valid=%b ctrl=%h rd=%0d exp 0/000000/0", m_ex_valid, m_ctrl, m_ex_rd);
        end
        n_vec++;
        if (m_in_ready !== 1'b0) begin
            n_err++; $display("FAIL reset_in_ready got %b exp 0", m_in_ready);
        end
        rst = 1'b0; in_valid = 1'b0;
        #1;
        n_vec++;
        if (m_in_ready !== 1'b1 || n_in_ready !== 1'b1) begin
            n_err++; $display("FAIL post_reset_in_ready got %b/%b exp 1/1", m_in_ready, n_in_ready);
        end
    endtask

    // One instruction per cycle from a table, each checked the cycle after issue.
    task automatic test_back_to_back();
        logic [31:0] t_instr [8];
        logic [22:0] t_exp   [8];
        logic [22:0] t_mask  [8];
        logic [4:0]  t_rd    [8];
        bit          t_rdchk [8];
        t_instr[0] = I_ADD3;  t_mask[0] = MASK_ALU; t_rd[0] = 5'd3; t_rdchk[0] = 1;
        t_exp[0] = {1'b1,1'b0,1'b0,1'b0,2'b00,5'b00000,2'b00,4'b0000,1'b0,3'b000,1'b0,1'b0};
        t_instr[1] = I_BGE;   t_mask[1] = MASK_BR;  t_rd[1] = 5'd0; t_rdchk[1] = 0;
        t_exp[1] = {1'b0,1'b1,1'b1,1'b0,2'b00,5'b00100,2'b00,4'b1111,1'b0,3'b000,1'b0,1'b0};
        t_instr[2] = I_SW;    t_mask[2] = MASK_MEM; t_rd[2] = 5'd0; t_rdchk[2] = 0;
        t_exp[2] = {1'b0,1'b0,1'b1,1'b1,2'b00,5'b01000,2'b10,4'b0000,1'b0,3'b000,1'b0,1'b0};
        t_instr[3] = I_JAL;   t_mask[3] = MASK_ALU; t_rd[3] = 5'd1; t_rdchk[3] = 1;
        t_exp[3] = {1'b1,1'b1,1'b1,1'b0,2'b10,5'b00010,2'b00,4'b1000,1'b0,3'b000,1'b0,1'b0};
        t_instr[4] = I_SLTI;  t_mask[4] = MASK_ALU; t_rd[4] = 5'd4; t_rdchk[4] = 1;
        t_exp[4] = {1'b1,1'b1,1'b0,1'b0,2'b11,5'b10000,2'b00,4'b0000,1'b0,3'b000,1'b0,1'b0};
        t_instr[5] = I_AUIPC; t_mask[5] = MASK_ALU; t_rd[5] = 5'd8; t_rdchk[5] = 1;
        t_exp[5] = {1'b1,1'b1,1'b1,1'b0,2'b00,5'b00001,2'b00,4'b0000,1'b0,3'b000,1'b0,1'b0};
        t_instr[6] = I_NOP;   t_mask[6] = MASK_ALL; t_rd[6] = 5'd0; t_rdchk[6] = 0;
        t_exp[6] = 23'h000000;
        t_instr[7] = I_ILL;   t_mask[7] = MASK_ILL; t_rd[7] = 5'd0; t_rdchk[7] = 0;
        t_exp[7] = 23'h000001;
        for (int i = 0; i < 8; i++) begin
            in_instr = t_instr[i]; in_valid = 1'b1;
            #1;
            n_vec++;
            if (m_in_ready !== 1'b1) begin
                n_err++; $display("FAIL b2b_in_ready[%0d] got %b exp 1", i, m_in_ready);
            end
            tick();
            n_vec++;
            if (m_ex_valid !== 1'b1 || (m_ctrl & t_mask[i]) !== (t_exp[i] & t_mask[i])
                || (t_rdchk[i] && m_ex_rd !== t_rd[i])) begin
                n_err++;
                $display("FAIL decode[%0d] instr=%h got valid=%b ctrl=%h rd=%0d exp valid=1 ctrl=%h (mask %h) rd=%0d",
                         i, t_instr[i], m_ex_valid, m_ctrl, m_ex_rd, t_exp[i], t_mask[i], t_rd[i]);
            end
        end
        in_valid = 1'b0;
        tick();
    endtask

    task automatic test_load_use();
        logic [22:0] exp_lw;
        exp_lw = {1'b1,1'b0,1'b1,1'b0,2'b01,5'b10000,2'b10,4'b0000,1'b1,3'b000,1'b0,1'b0};
        do_reset();
        in_instr = I_LW5; in_valid = 1'b1;
        tick();
        in_instr = I_ADD6;
        #1;
        n_vec++;
        if (m_ex_valid !== 1'b1 || (m_ctrl & MASK_MEM) !== exp_lw || m_ex_rd !== 5'd5) begin
            n_err++; $display("FAIL lw_decode got valid=%b ctrl=%h rd=%0d exp 1/%h/5", m_ex_valid, m_ctrl, m_ex_rd, exp_lw);
        end
        n_vec++;
        if (m_in_ready !== 1'b0) begin
            n_err++; $display("FAIL load_use_stall in_ready got %b exp 0", m_in_ready);
        end
        tick();
        n_vec++;
        if (m_ex_valid !== 1'b0) begin
            n_err++; $display("FAIL load_use_bubble ex_valid got %b exp 0", m_ex_valid);
        end
        #1;
        n_vec++;
        if (m_in_ready !== 1'b1) begin
            n_err++; $display("FAIL load_use_release in_ready got %b exp 1", m_in_ready);
        end
        tick();
        in_valid = 1'b0;
        n_vec++;
        if (m_ex_valid !== 1'b1 || m_ex_rd !== 5'd6 || m_RegWe !== 1'b1) begin
            n_err++; $display("FAIL load_use_issue got valid=%b rd=%0d we=%b exp 1/6/1", m_ex_valid, m_ex_rd, m_RegWe);
        end
        tick();
    endtask

    task automatic test_divide();
        logic [22:0] exp_div;
        int stalled;
        exp_div = {1'b1,1'b0,1'b0,1'b0,2'b00,5'b00000,2'b00,4'b0000,1'b0,3'b100,1'b1,1'b0};
        stalled = 0;
        do_reset();
        in_instr = I_DIV7; in_valid = 1'b1;
        tick();
        in_instr = I_ADD3;
        n_vec++;
        if (m_ex_valid !== 1'b1 || (m_ctrl & MASK_ALU) !== exp_div || m_ex_rd !== 5'd7) begin
            n_err++; $display("FAIL div_decode got valid=%b ctrl=%h rd=%0d exp 1/%h/7", m_ex_valid, m_ctrl, m_ex_rd, exp_div);
        end
        for (int k = 0; k < 40; k++) begin
            #1;
            if (m_in_ready === 1'b1) break;
            stalled++;
            tick();
        end
        n_vec++;
        if (stalled != 7) begin
            n_err++; $display("FAIL div_stall_cycles got %0d exp 7", stalled);
        end
        tick();
        in_valid = 1'b0;
        n_vec++;
        if (m_ex_valid !== 1'b1 || m_ex_rd !== 5'd3 || m_ex_mdu !== 1'b0) begin
            n_err++; $display("FAIL div_next_issue got valid=%b rd=%0d mdu=%b exp 1/3/0", m_ex_valid, m_ex_rd, m_ex_mdu);
        end
        tick();
    endtask

    task automatic test_m_disabled();
        do_reset();
        in_instr = I_DIV7; in_valid = 1'b1;
        tick();
        in_instr = I_ADD3;
        n_vec++;
        if (n_ex_valid !== 1'b1 || (n_ctrl & MASK_ILL) !== 23'h000001) begin
            n_err++; $display("FAIL nom_div_illegal got valid=%b ctrl=%h exp 1/000001 (mask %h)", n_ex_valid, n_ctrl, MASK_ILL);
        end
        #1;
        n_vec++;
        if (n_in_ready !== 1'b1) begin
            n_err++; $display("FAIL nom_no_stall in_ready got %b exp 1", n_in_ready);
        end
        tick();
        in_valid = 1'b0;
        n_vec++;
        if (n_ex_rd !== 5'd3 || n_ex_illegal !== 1'b0) begin
            n_err++; $display("FAIL nom_next got rd=%0d ill=%b exp 3/0", n_ex_rd, n_ex_illegal);
        end
        tick();
    endtask

    task automatic test_flush();
        // flush while EX holds (ex_ready=0)
        do_reset();
        in_instr = I_ADD3; in_valid = 1'b1;
        tick();
        ex_ready = 1'b0; in_instr = I_SLTI;
        #1;
        n_vec++;
        if (m_in_ready !== 1'b0) begin
            n_err++; $display("FAIL hold_in_ready got %b exp 0", m_in_ready);
        end
        tick();
        n_vec++;
        if (m_ex_valid !== 1'b1 || m_ex_rd !== 5'd3) begin
            n_err++; $display("FAIL hold_keeps got valid=%b rd=%0d exp 1/3", m_ex_valid, m_ex_rd);
        end
        flush = 1'b1;
        #1;
        n_vec++;
        if (m_in_ready !== 1'b1) begin
            n_err++; $display("FAIL flush_hold_in_ready got %b exp 1", m_in_ready);
        end
        tick();
        flush = 1'b0; in_valid = 1'b0; ex_ready = 1'b1;
        n_vec++;
        if (m_ex_valid !== 1'b0) begin
            n_err++; $display("FAIL flush_hold_kill ex_valid got %b exp 0", m_ex_valid);
        end
        tick();
        // flush in the middle of a divide wait
        in_instr = I_DIV7; in_valid = 1'b1;
        tick();
        in_instr = I_ADD3;
        tick();
        tick();
        #1;
        n_vec++;
        if (m_in_ready !== 1'b0) begin
            n_err++; $display("FAIL div_wait_in_ready got %b exp 0", m_in_ready);
        end
        flush = 1'b1;
        #1;
        n_vec++;
        if (m_in_ready !== 1'b1) begin
            n_err++; $display("FAIL flush_div_in_ready got %b exp 1", m_in_ready);
        end
        tick();
        flush = 1'b0;
        n_vec++;
        if (m_ex_valid !== 1'b0) begin
            n_err++; $display("FAIL flush_div_kill ex_valid got %b exp 0", m_ex_valid);
        end
        #1;
        n_vec++;
        if (m_in_ready !== 1'b1) begin
            n_err++; $display("FAIL flush_div_run in_ready got %b exp 1", m_in_ready);
        end
        tick();
        in_valid = 1'b0;
        n_vec++;
        if (m_ex_valid !== 1'b1 || m_ex_rd !== 5'd3) begin
            n_err++; $display("FAIL flush_div_reissue got valid=%b rd=%0d exp 1/3", m_ex_valid, m_ex_rd);
        end
        tick();
        // flush coinciding with a load-use hazard
        in_instr = I_LW5; in_valid = 1'b1;
        tick();
        in_instr = I_ADD6; flush = 1'b1;
        #1;
        n_vec++;
        if (m_in_ready !== 1'b1) begin
            n_err++; $display("FAIL flush_hazard_in_ready got %b exp 1", m_in_ready);
        end
        tick();
        flush = 1'b0; in_valid = 1'b0;
        n_vec++;
        if (m_ex_valid !== 1'b0) begin
            n_err++; $display("FAIL flush_hazard_drop ex_valid got %b exp 0", m_ex_valid);
        end
        tick();
    endtask

    task automatic test_reset_mid_div();
        do_reset();
        in_instr = I_DIV7; in_valid = 1'b1;
        tick();
        in_instr = I_ADD3;
        tick();
        rst = 1'b1;
        #1;
        n_vec++;
        if (m_in_ready !== 1'b0) begin
            n_err++; $display("FAIL rst_div_in_ready got %b exp 0", m_in_ready);
        end
        tick();
        rst = 1'b0;
        n_vec++;
        if (m_ex_valid !== 1'b0 || m_ctrl !== 23'h0) begin
            n_err++; $display("FAIL rst_div_state got valid=%b ctrl=%h exp 0/000000", m_ex_valid, m_ctrl);
        end
        #1;
        n_vec++;
        if (m_in_ready !== 1'b1) begin
            n_err++; $display("FAIL rst_div_run in_ready got %b exp 1", m_in_ready);
        end
        tick();
        in_valid = 1'b0;
        n_vec++;
        if (m_ex_valid !== 1'b1 || m_ex_rd !== 5'd3) begin
            n_err++; $display("FAIL rst_div_issue got valid=%b rd=%0d exp 1/3", m_ex_valid, m_ex_rd);
        end
        tick();
    endtask

    initial begin
        rst = 1'b1; in_valid = 1'b0; flush = 1'b0; ex_ready = 1'b1; in_instr = 32'h0;
        test_reset();
        test_back_to_back();
        test_load_use();
        test_divide();
        test_m_disabled();
        test_flush();
        test_reset_mid_div();
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule

// File: doc/ctrl_pipe.md
# ctrl_pipe

Registered instruction-decode/control stage for the RV32I core, generalised from the single-cycle controller. It decodes a full 32-bit instruction into the datapath control bundle and holds the result in an ID/EX pipeline register. It adds a valid/ready handshake, load-use hazard stalls, a multi-cycle divide stall (optional M extension), branch flush and illegal-opcode flagging. It sits between the fetch buffer and the execute stage.

## Interface
- ENABLE_M, 0: 1 decodes RV32M (opcode 0110011, func7 0000001); 0 flags those as illegal.
- DIV_LAT, 8: total EX cycles of DIV/DIVU/REM/REMU, range 2..32.
- clk  in  1  system clock, rising edge.
- rst  in  1  synchronous reset, active-high.
- in_valid  in  1  fetch offers in_instr.
- in_instr  in  32  instruction word.
- in_ready  out  1  stage accepts in_instr this cycle.
- flush  in  1  EX redirect (taken branch/jump); kills ID/EX and the offered instruction.
- ex_ready  in  1  EX consumes the ID/EX register this cycle.
- ex_valid  out  1  ID/EX holds a real instruction.
- RegWe, ASel, BSel, DRAMWE  out  1 each  control bits.
- RWSel  out  2  write-back select.
- SextOpe  out  5  one-hot {i,s,b,j,u}.
- DRAM_EX_TYPE  out  2  func3[1:0].
- PCCTRL  out  4  {BRANCH, BJ, cond[1:0]}.
- ex_rd  out  5  destination register.
- ex_is_load  out  1  instruction is a load.
- ex_mdu_op  out  3  func3 of an M instruction; valid with ex_mdu.
- ex_mdu  out  1  M-extension instruction.
- ex_illegal  out  1  unknown opcode.

## Operation
- Encodings:
  - ASel: 0 = reg, 1 = PC.
  - BSel: 0 = reg, 1 = imm.
  - RWSel: 00 = ALU, 01 = DRAM, 10 = PC, 11 = COMP.
  - PCCTRL cond: 00 = EQ, 01 = NE, 10 = LT, 11 = GEQ.
- Type decode on instr[6:2]:
  - 01100: R.
  - 01101 and 00101: U.
  - 11011: J.
  - 01000: S.
  - 11000: B.
  - 00000, 00100, 11001: I.
  - Any other value: ex_illegal=1, SextOpe=0, RegWe=0, DRAMWE=0.
- instr[1:0]!=11 is a NOP: control bits are all 0, ex_illegal=0, and the NOP still occupies a slot (ex_valid=1).
- RegWe:
  - 1 unless S, B, NOP or illegal.
  - Forced 0 when rd==0.
- ASel=1 for J, B, AUIPC, SLT/SLTU/SLTI/SLTIU; else 0.
- BSel=0 for R-type non-compare and for SLTI/SLTIU; else 1.
- RWSel (priority order):
  - Load: 01.
  - Else SLT*: 11.
  - Else JAL/JALR: 10.
  - Else: 00.
- DRAMWE=1 only for S.
- PCCTRL:
  - BRANCH = B | JAL | JALR.
  - BJ = B.
  - cond from func3: 000 → EQ, 001 → NE, 100 and 110 → LT, other values → GEQ.
- rs usage:
  - Uses rs1: R, I, S, B.
  - Uses rs2: R, S, B.
  - U and J use neither.
- Load-use hazard: ex_valid & ex_is_load & ex_rd!=0 & in_valid & (rs1 used and equal to ex_rd, or rs2 used and equal to ex_rd). When the hazard holds:
  - in_ready=0.
  - If ex_ready, ID/EX loads a bubble (ex_valid=0).
- Advance condition: adv = ~ex_valid | ex_ready.
- in_ready = adv & ~hazard & (state==RUN) & ~rst.
- On accept (in_valid & in_ready), ID/EX loads the decoded bundle and ex_valid=1.
- If adv and no accept, ex_valid=0.
- If ~adv, ID/EX holds all values.
- FSM, RUN → DIV_WAIT: on accepting a DIV/DIVU/REM/REMU (ENABLE_M=1, func3[2]=1), cnt ← DIV_LAT-1.
- FSM, DIV_WAIT:
  - in_ready=0; cnt decrements each cycle.
  - At cnt==1 the FSM returns to RUN, so the next accept happens DIV_LAT cycles after the divide was accepted.
- MUL* does not stall.
- Flush has priority over hold, hazard and DIV_WAIT:
  - Next cycle ex_valid=0.
  - The FSM returns to RUN, cnt=0.
  - in_ready=1 during the flush cycle, and the offered instruction is consumed and discarded.
- Reset: ex_valid=0, all control outputs, ex_rd, ex_mdu_op, ex_mdu, ex_illegal, ex_is_load = 0; state=RUN; cnt=0.

## Timing
- Decode latency: 1 cycle, accept edge to outputs valid.
- Sustained throughput: 1 instruction/cycle with no hazard.
- Load-use costs 1 bubble cycle.
- A divide blocks issue for DIV_LAT-1 cycles.
- All outputs are registered. in_ready is combinational from in_instr, in_valid, ex_ready, flush and state.
- rst mid-DIV_WAIT or mid-stall: next cycle is the reset state, with no partial issue.
- flush together with ex_ready=0: flush wins.
- flush in the same cycle as a hazard: no stall; the instruction is discarded.

## Test plan
- Reset then 0x002081B3 (add x3,x1,x2) with ex_ready=1 → next cycle ex_valid=1, RegWe=1, ASel=0, BSel=0, RWSel=00, SextOpe=00000, ex_rd=3.
- 0x0000A283 (lw x5,0(x1)) then 0x00128333 (add x6,x5,x1) → in_ready=0 for 1 cycle and one bubble (ex_valid=0). The add issues the following cycle.
- ENABLE_M=1, DIV_LAT=8, 0x0220C3B3 (div x7,x1,x2) then add → ex_mdu=1, ex_mdu_op=100. in_ready=0 for 7 cycles; the add is accepted 8 cycles after the div.
- 0x0020D463 (bge x1,x2,+8) → PCCTRL=1111, RegWe=0, ASel=1, SextOpe=00100.
- Flush asserted with ex_ready=0, and again mid-DIV_WAIT → ex_valid=0 next cycle, state=RUN, the offered instruction is dropped.
- Opcode 0x0000007F → ex_illegal=1, RegWe=0, DRAMWE=0. With ENABLE_M=0, 0x0220C3B3 → ex_illegal=1 and no stall.
